// File: rtl/qedmma_corr_pkg.sv
// Shared types and constants for the QEDMMA correlation result streamer.
package qedmma_corr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } streamer_state_e;

  localparam logic [1:0] TID_I   = 2'd0;
  localparam logic [1:0] TID_Q   = 2'd1;
  localparam logic [1:0] TID_MAG = 2'd2;

  localparam logic MAG_MODE_SUM    = 1'b0;
  localparam logic MAG_MODE_MAXMIN = 1'b1;

  // Lowest enabled channel in the emit mask (I before Q before Mag).
  function automatic logic [1:0] first_chan(input logic [2:0] mask);
    first_chan = TID_I;
    for (int c = 2; c >= 0; c--) begin
      if (mask[c[1:0]]) first_chan = c[1:0];
    end
  endfunction

  // Highest enabled channel: the block whose tlast ends the emit phase.
  function automatic logic [1:0] last_chan(input logic [2:0] mask);
    last_chan = TID_I;
    for (int c = 0; c <= 2; c++) begin
      if (mask[c[1:0]]) last_chan = c[1:0];
    end
  endfunction

  // Next enabled channel strictly above cur; only used when one exists.
  function automatic logic [1:0] next_chan(input logic [2:0] mask, input logic [1:0] cur);
    next_chan = cur;
    for (int c = 2; c >= 0; c--) begin
      if (mask[c[1:0]] && (c[1:0] > cur)) next_chan = c[1:0];
    end
  endfunction

endpackage

// File: rtl/qedmma_iq_mag_unit.sv
// Two-stage magnitude pipeline: stage 1 takes absolute values, stage 2
// combines them as |I|+|Q| or max+min/2. A lane tag travels alongside.
module qedmma_iq_mag_unit
  import qedmma_corr_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int TAG_W     = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        valid_i,
  input  logic                        mode_i,
  input  logic signed [ACC_WIDTH-1:0] i_i,
  input  logic signed [ACC_WIDTH-1:0] q_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        valid_o,
  output logic [ACC_WIDTH:0]          mag_o,
  output logic [TAG_W-1:0]            tag_o
);

  localparam int MAG_W = ACC_WIDTH + 1;

  logic [MAG_W-1:0] extI, extQ, absI, absQ, maxV, minV, mag_d;
  logic             s1Valid_q, s1Mode_q;
  logic [MAG_W-1:0] s1AbsI_q, s1AbsQ_q;
  logic [TAG_W-1:0] s1Tag_q;

  // Widen by one bit before negating so the most negative input stays positive.
  always_comb begin
    extI = MAG_W'(i_i);
    extQ = MAG_W'(q_i);
    absI = extI[MAG_W-1] ? (~extI) + MAG_W'(1) : extI;
    absQ = extQ[MAG_W-1] ? (~extQ) + MAG_W'(1) : extQ;
  end

  // Combine the registered absolute values according to the frame's mode.
  always_comb begin
    maxV  = (s1AbsI_q >= s1AbsQ_q) ? s1AbsI_q : s1AbsQ_q;
    minV  = (s1AbsI_q >= s1AbsQ_q) ? s1AbsQ_q : s1AbsI_q;
    mag_d = (s1Mode_q == MAG_MODE_MAXMIN) ? maxV + (minV >> 1) : s1AbsI_q + s1AbsQ_q;
  end

  // Valid bits are cleared on reset and when an aborted frame must not leak through.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1Valid_q <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      s1Valid_q <= valid_i;
      valid_o   <= s1Valid_q;
    end
  end

  // Datapath registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    s1AbsI_q <= absI;
    s1AbsQ_q <= absQ;
    s1Mode_q <= mode_i;
    s1Tag_q  <= tag_i;
    mag_o    <= mag_d;
    tag_o    <= s1Tag_q;
  end

endmodule

// File: rtl/qedmma_iq_result_streamer.sv
// Captures one correlation frame of I/Q lanes, tracks peak and detections,
// then streams the I, Q and magnitude blocks out over AXI-Stream.
module qedmma_iq_result_streamer
  import qedmma_corr_pkg::*;
#(
  parameter  int NUM_LANES      = 512,
  parameter  int ACC_WIDTH      = 48,
  parameter  int AXI_DATA_WIDTH = 64,
  localparam int LANE_W         = $clog2(NUM_LANES),
  localparam int MAG_W          = ACC_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_mag_mode,
  input  logic [2:0]                  i_chan_mask,
  input  logic [MAG_W-1:0]            i_threshold,
  input  logic signed [ACC_WIDTH-1:0] s_i_data,
  input  logic signed [ACC_WIDTH-1:0] s_q_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [1:0]                  m_axis_tid,
  output logic [LANE_W-1:0]           m_axis_tuser,
  output logic [LANE_W-1:0]           o_peak_lane,
  output logic [MAG_W-1:0]            o_peak_mag,
  output logic                        o_peak_valid,
  output logic [LANE_W:0]             o_det_count,
  output logic [31:0]                 o_frame_count,
  output logic                        o_frame_err,
  output logic                        o_busy
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  streamer_state_e state_q, state_d;
  logic                cfgMode_q;
  logic [2:0]          cfgMask_q;
  logic [MAG_W-1:0]    cfgThr_q;
  logic [LANE_W-1:0]   capLane_q;
  logic                drainCnt_q;
  logic [MAG_W-1:0]    runPeakMag_q, runPeakMag_d;
  logic [LANE_W-1:0]   runPeakLane_q, runPeakLane_d;
  logic [LANE_W:0]     runDet_q, runDet_d;
  logic                accept, isLastLane, frameErrEvt, frameEndEvt, drainExit, emitDone;
  logic                magValid;
  logic [MAG_W-1:0]    magData;
  logic [LANE_W-1:0]   magLane;
  logic [ACC_WIDTH-1:0] iBuf_q [NUM_LANES];
  logic [ACC_WIDTH-1:0] qBuf_q [NUM_LANES];
  logic [MAG_W-1:0]     magBuf_q [NUM_LANES];
  logic                issueActive_q, issue, moveAB, issueLastLane;
  logic [1:0]          emChan_q, lastChan;
  logic [LANE_W-1:0]   emLane_q;
  logic [AXI_DATA_WIDTH-1:0] issueData, aData_q;
  logic                aValid_q, aLast_q;
  logic [1:0]          aTid_q;
  logic [LANE_W-1:0]   aUser_q;

  assign s_ready     = (state_q == ST_CAPTURE);
  assign o_busy      = (state_q != ST_IDLE);
  assign accept      = s_valid && s_ready;
  assign isLastLane  = (capLane_q == LAST_LANE);
  assign frameErrEvt = accept && (s_last != isLastLane);
  assign frameEndEvt = accept && s_last && isLastLane;
  assign drainExit   = (state_q == ST_DRAIN) && drainCnt_q;
  assign lastChan    = last_chan(cfgMask_q);
  assign emitDone    = (state_q == ST_EMIT) && m_axis_tvalid && m_axis_tready &&
                       m_axis_tlast && (m_axis_tid == lastChan);
  assign moveAB        = aValid_q && (!m_axis_tvalid || m_axis_tready);
  assign issue         = issueActive_q && (!aValid_q || moveAB);
  assign issueLastLane = (emLane_q == LAST_LANE);

  qedmma_iq_mag_unit #(
    .ACC_WIDTH(ACC_WIDTH),
    .TAG_W    (LANE_W)
  ) u_mag (
    .clk    (clk),
    .rst    (rst),
    .flush_i(frameErrEvt),
    .valid_i(accept),
    .mode_i (cfgMode_q),
    .i_i    (s_i_data),
    .q_i    (s_q_data),
    .tag_i  (capLane_q),
    .valid_o(magValid),
    .mag_o  (magData),
    .tag_o  (magLane)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a bad frame returns to IDLE, an empty mask skips EMIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (i_enable) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (frameErrEvt)      state_d = ST_IDLE;
        else if (frameEndEvt) state_d = ST_DRAIN;
      end
      ST_DRAIN:   if (drainCnt_q) state_d = (cfgMask_q != 3'b000) ? ST_EMIT : ST_DONE;
      ST_EMIT:    if (emitDone) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Running peak (strict > keeps the lowest lane on ties) and detection count.
  always_comb begin
    runPeakMag_d  = runPeakMag_q;
    runPeakLane_d = runPeakLane_q;
    runDet_d      = runDet_q;
    if (magValid) begin
      if (magData > runPeakMag_q) begin
        runPeakMag_d  = magData;
        runPeakLane_d = magLane;
      end
      if (magData >= cfgThr_q) runDet_d = runDet_q + (LANE_W + 1)'(1);
    end
  end

  // Configuration latch, lane counter, drain timer, trackers and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfgMode_q     <= MAG_MODE_SUM;
      cfgMask_q     <= 3'b000;
      cfgThr_q      <= '0;
      capLane_q     <= '0;
      drainCnt_q    <= 1'b0;
      runPeakMag_q  <= '0;
      runPeakLane_q <= '0;
      runDet_q      <= '0;
      o_frame_err   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && i_enable) begin
        cfgMode_q     <= i_mag_mode;
        cfgMask_q     <= i_chan_mask;
        cfgThr_q      <= i_threshold;
        capLane_q     <= '0;
        runPeakMag_q  <= '0;
        runPeakLane_q <= '0;
        runDet_q      <= '0;
      end else begin
        runPeakMag_q  <= runPeakMag_d;
        runPeakLane_q <= runPeakLane_d;
        runDet_q      <= runDet_d;
        if (accept) capLane_q <= capLane_q + LANE_W'(1);
      end
      drainCnt_q <= (state_q == ST_DRAIN) ? ~drainCnt_q : 1'b0;
      if (frameErrEvt) o_frame_err <= 1'b1;
    end
  end

  // Frame status is published only when a good frame leaves DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_peak_lane   <= '0;
      o_peak_mag    <= '0;
      o_det_count   <= '0;
      o_frame_count <= '0;
      o_peak_valid  <= 1'b0;
    end else begin
      o_peak_valid <= drainExit;
      if (drainExit) begin
        o_peak_lane   <= runPeakLane_d;
        o_peak_mag    <= runPeakMag_d;
        o_det_count   <= runDet_d;
        o_frame_count <= o_frame_count + 32'd1;
      end
    end
  end

  // Lane buffers: I/Q written on accept, magnitude when the pipeline delivers it.
  always_ff @(posedge clk) begin
    if (accept) begin
      iBuf_q[capLane_q] <= s_i_data;
      qBuf_q[capLane_q] <= s_q_data;
    end
    if (magValid) magBuf_q[magLane] <= magData;
  end

  // Select the buffer word for the beat being fetched; I/Q sign-extend, Mag zero-extends.
  always_comb begin
    issueData = '0;
    unique case (emChan_q)
      TID_I:   issueData = AXI_DATA_WIDTH'($signed(iBuf_q[emLane_q]));
      TID_Q:   issueData = AXI_DATA_WIDTH'($signed(qBuf_q[emLane_q]));
      default: issueData = AXI_DATA_WIDTH'(magBuf_q[emLane_q]);
    endcase
  end

  // Emit sequencer feeding a fetch stage (A) and the AXI output stage; A is
  // refilled whenever it empties so a held-high tready sees one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      issueActive_q <= 1'b0;
      emChan_q      <= TID_I;
      emLane_q      <= '0;
      aValid_q      <= 1'b0;
      aData_q       <= '0;
      aTid_q        <= TID_I;
      aUser_q       <= '0;
      aLast_q       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= TID_I;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (drainExit) begin
        issueActive_q <= (cfgMask_q != 3'b000);
        emChan_q      <= first_chan(cfgMask_q);
        emLane_q      <= '0;
      end else if (issue) begin
        emLane_q <= emLane_q + LANE_W'(1);
        if (issueLastLane && emChan_q == lastChan) issueActive_q <= 1'b0;
        else if (issueLastLane)                    emChan_q <= next_chan(cfgMask_q, emChan_q);
      end
      if (issue) begin
        aValid_q <= 1'b1;
        aData_q  <= issueData;
        aTid_q   <= emChan_q;
        aUser_q  <= emLane_q;
        aLast_q  <= issueLastLane;
      end else if (moveAB) begin
        aValid_q <= 1'b0;
      end
      if (moveAB) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= aData_q;
        m_axis_tid    <= aTid_q;
        m_axis_tuser  <= aUser_q;
        m_axis_tlast  <= aLast_q;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qedmma_iq_result_streamer.sv
// Directed scoreboard bench for the IQ result streamer (8 lanes, 16-bit accumulators).
module tb_qedmma_iq_result_streamer;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = AW + 1;
  localparam int LW = 3;

  typedef struct {
    logic [1:0]    tid;
    logic [LW-1:0] user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_enable, i_mag_mode;
  logic [2:0]           i_chan_mask;
  logic [MW-1:0]        i_threshold;
  logic signed [AW-1:0] s_i_data, s_q_data;
  logic                 s_valid, s_last, s_ready;
  logic [DW-1:0]        m_axis_tdata;
  logic                 m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]           m_axis_tid;
  logic [LW-1:0]        m_axis_tuser, o_peak_lane;
  logic [MW-1:0]        o_peak_mag;
  logic                 o_peak_valid, o_frame_err, o_busy;
  logic [LW:0]          o_det_count;
  logic [31:0]          o_frame_count;

  beat_t expQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    beatsSeen = 0;
  int    peakPulses = 0;
  int    laneI [N];
  int    laneQ [N];
  logic  stallEn = 1'b0;

  qedmma_iq_result_streamer #(
    .NUM_LANES(N), .ACC_WIDTH(AW), .AXI_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_mag_mode(i_mag_mode),
    .i_chan_mask(i_chan_mask), .i_threshold(i_threshold),
    .s_i_data(s_i_data), .s_q_data(s_q_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tuser(m_axis_tuser), .o_peak_lane(o_peak_lane), .o_peak_mag(o_peak_mag),
    .o_peak_valid(o_peak_valid), .o_det_count(o_det_count), .o_frame_count(o_frame_count),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Compare one observed value against its required value and tally the outcome.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Reference magnitude for the bench's own expectations.
  function automatic int magModel(input int i, input int q, input logic mode);
    int ai, aq, mx, mn;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    mx = (ai >= aq) ? ai : aq;
    mn = (ai >= aq) ? aq : ai;
    return mode ? (mx + mn / 2) : (ai + aq);
  endfunction

  // Drive one frame; queue the expected beats only for a well-formed frame.
  task automatic applyStimulus(input logic mode, input logic [2:0] mask, input int thr,
                               input int lastLane, input logic dropLast);
    int    n;
    beat_t b;
    if (lastLane == N - 1 && !dropLast) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (mask[ch[1:0]]) begin
          for (int ln = 0; ln < N; ln++) begin
            b.tid  = ch[1:0];
            b.user = ln[LW-1:0];
            b.last = (ln == N - 1);
            if (ch == 0)      b.data = 64'(longint'(laneI[ln]));
            else if (ch == 1) b.data = 64'(longint'(laneQ[ln]));
            else              b.data = 64'(magModel(laneI[ln], laneQ[ln], mode));
            expQ.push_back(b);
          end
        end
      end
    end
    @(posedge clk); #1;
    i_mag_mode  = mode;
    i_chan_mask = mask;
    i_threshold = MW'(thr);
    i_enable    = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("captureStart", 64'(s_ready), 64'(1));
    i_enable    = 1'b0;
    i_mag_mode  = ~mode;
    i_chan_mask = ~mask;
    i_threshold = '1;
    for (int k = 0; k <= lastLane; k++) begin
      s_valid  = 1'b1;
      s_i_data = AW'(laneI[k]);
      s_q_data = AW'(laneQ[k]);
      s_last   = (k == lastLane) && !dropLast;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Bounded wait for the streamer to return to IDLE, then confirm all beats arrived.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, 64'(o_busy), 64'(0));
    repeat (2) @(negedge clk);
    checkOutput({name, "_beatsLeft"}, 64'(expQ.size()), 64'(0));
  endtask

  // Frame status check against hand-computed values.
  task automatic checkStatus(input string name, input int lane, input int mag, input int det,
                             input int frames, input logic err, input int pulses);
    checkOutput({name, "_peakLane"}, 64'(o_peak_lane), 64'(lane));
    checkOutput({name, "_peakMag"}, 64'(o_peak_mag), 64'(mag));
    checkOutput({name, "_detCount"}, 64'(o_det_count), 64'(det));
    checkOutput({name, "_frameCount"}, 64'(o_frame_count), 64'(frames));
    checkOutput({name, "_frameErr"}, 64'(o_frame_err), 64'(err));
    checkOutput({name, "_peakPulses"}, 64'(peakPulses), 64'(pulses));
  endtask

  // Downstream ready: always high unless the stall pattern is enabled (~30% low).
  initial begin : readyDriver
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = stallEn ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Count o_peak_valid cycles; a single-cycle pulse adds exactly one per good frame.
  initial begin : pulseMonitor
    forever begin
      @(negedge clk);
      if (!rst && o_peak_valid) peakPulses++;
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin : beatMonitor
    beat_t         e;
    logic          stalled;
    logic [DW-1:0] hData;
    logic [1:0]    hTid;
    logic [LW-1:0] hUser;
    logic          hLast;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("holdValid", 64'(m_axis_tvalid), 64'(1));
          checkOutput("holdBeat", {m_axis_tdata[58:0], m_axis_tid, m_axis_tuser},
                      {hData[58:0], hTid, hUser});
          checkOutput("holdLast", 64'(m_axis_tlast), 64'(hLast));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beatsSeen++;
          stalled = 1'b0;
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedBeat: got tid=%0d lane=%0d, required no beat",
                     m_axis_tid, m_axis_tuser);
          end else begin
            e = expQ.pop_front();
            checkOutput("beatTid", 64'(m_axis_tid), 64'(e.tid));
            checkOutput("beatLane", 64'(m_axis_tuser), 64'(e.user));
            checkOutput("beatLast", 64'(m_axis_tlast), 64'(e.last));
            checkOutput("beatData", m_axis_tdata, e.data);
          end
        end else if (m_axis_tvalid) begin
          stalled = 1'b1;
          hData = m_axis_tdata;
          hTid  = m_axis_tid;
          hUser = m_axis_tuser;
          hLast = m_axis_tlast;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed sequence of frames.
  initial begin : mainSeq
    int n;
    int base;
    rst = 1'b1;
    i_enable = 1'b0; i_mag_mode = 1'b0; i_chan_mask = 3'b000; i_threshold = '0;
    s_i_data = '0; s_q_data = '0; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("rst_sready", 64'(s_ready), 64'(0));
    checkOutput("rst_busy", 64'(o_busy), 64'(0));
    checkOutput("rst_frameCount", 64'(o_frame_count), 64'(0));
    checkOutput("rst_frameErr", 64'(o_frame_err), 64'(0));
    checkOutput("rst_peakValid", 64'(o_peak_valid), 64'(0));
    rst = 1'b0;

    // Sum mode, all channels: lane 5 dominates with 300+400.
    for (int k = 0; k < N; k++) begin laneI[k] = 1; laneQ[k] = 1; end
    laneI[5] = -300; laneQ[5] = 400;
    applyStimulus(1'b0, 3'b111, 2, N - 1, 1'b0);
    waitIdle("frameA");
    checkStatus("frameA", 5, 700, 8, 1, 1'b0, 1);

    // Max+min/2 mode with the most negative I; 32768 + 50.
    for (int k = 0; k < N; k++) begin laneI[k] = 0; laneQ[k] = 0; end
    laneI[2] = -32768; laneQ[2] = 100;
    applyStimulus(1'b1, 3'b111, 1000, N - 1, 1'b0);
    waitIdle("frameB");
    checkStatus("frameB", 2, 32818, 1, 2, 1'b0, 2);

    // Tie between lanes 3 and 6: lower lane wins; Mag block only.
    for (int k = 0; k < N; k++) begin laneI[k] = 0; laneQ[k] = 0; end
    laneI[3] = 500; laneI[6] = 500;
    applyStimulus(1'b0, 3'b100, 500, N - 1, 1'b0);
    waitIdle("frameC");
    checkStatus("frameC", 3, 500, 2, 3, 1'b0, 3);

    // Early s_last at lane 4: discarded, error latched, status untouched.
    applyStimulus(1'b0, 3'b111, 0, 4, 1'b0);
    waitIdle("frameD");
    checkStatus("frameD", 3, 500, 2, 3, 1'b1, 3);

    // Final lane without s_last is also a framing error.
    applyStimulus(1'b0, 3'b111, 0, N - 1, 1'b1);
    waitIdle("frameE2");
    checkStatus("frameE2", 3, 500, 2, 3, 1'b1, 3);

    // Good frame after errors; mags 23,12,1,10,21,32,43,54.
    for (int k = 0; k < N; k++) begin laneI[k] = k * 10 - 20; laneQ[k] = 3 - k; end
    applyStimulus(1'b0, 3'b001, 0, N - 1, 1'b0);
    waitIdle("frameE");
    checkStatus("frameE", 7, 54, 8, 4, 1'b1, 4);

    // Random back-pressure, I and Q blocks; mags 100+7k+floor(3k/2).
    for (int k = 0; k < N; k++) begin laneI[k] = 100 + 7 * k; laneQ[k] = -3 * k; end
    stallEn = 1'b1;
    applyStimulus(1'b1, 3'b011, 0, N - 1, 1'b0);
    waitIdle("frameF");
    stallEn = 1'b0;
    checkStatus("frameF", 7, 159, 8, 5, 1'b1, 5);

    // Reset after the tenth emitted beat of a 24-beat frame.
    for (int k = 0; k < N; k++) begin laneI[k] = k + 1; laneQ[k] = -k; end
    base = beatsSeen;
    applyStimulus(1'b0, 3'b111, 0, N - 1, 1'b0);
    n = 0;
    while ((beatsSeen - base) < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("frameG_tenBeats", 64'(beatsSeen - base), 64'(10));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("frameG_tvalidAfterRst", 64'(m_axis_tvalid), 64'(0));
    checkOutput("frameG_busyAfterRst", 64'(o_busy), 64'(0));
    checkOutput("frameG_frameCount", 64'(o_frame_count), 64'(0));
    checkOutput("frameG_frameErr", 64'(o_frame_err), 64'(0));
    checkOutput("frameG_peakMag", 64'(o_peak_mag), 64'(0));
    checkOutput("frameG_peakLane", 64'(o_peak_lane), 64'(0));
    checkOutput("frameG_detCount", 64'(o_det_count), 64'(0));
    rst = 1'b0;
    expQ.delete();
    peakPulses = 0;

    // Clean frame after reset: Q block only, mags 0..7, threshold 3.
    for (int k = 0; k < N; k++) begin laneI[k] = k; laneQ[k] = 0; end
    applyStimulus(1'b0, 3'b010, 3, N - 1, 1'b0);
    waitIdle("frameH");
    checkStatus("frameH", 7, 7, 5, 1, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qedmma_iq_result_streamer.md
QEDMMA_IQ_RESULT_STREAMER -- requirements
Module: qedmma_iq_result_streamer

Interface
REQ-001 Parameter NUM_LANES, default 512, lanes per correlation frame (power of 2, >=4).
REQ-002 Parameter ACC_WIDTH, default 48, signed I/Q accumulator width.
REQ-003 Parameter AXI_DATA_WIDTH, default 64, output width; SHALL satisfy AXI_DATA_WIDTH >= ACC_WIDTH+1.
REQ-004 Derived constants: LANE_W = clog2(NUM_LANES); MAG_W = ACC_WIDTH+1.
REQ-005 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-006 Port list, one per line, as name / direction / width / meaning:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_enable  in  1  permits start of a new capture frame
i_mag_mode  in  1  0 = |I|+|Q|; 1 = max(|I|,|Q|) + min(|I|,|Q|)/2; sampled at frame start
i_chan_mask  in  3  emit enables: bit0 = I, bit1 = Q, bit2 = Mag; sampled at frame start
i_threshold  in  MAG_W  detection threshold; sampled at frame start
s_i_data  in  ACC_WIDTH  signed I accumulator for the current lane
s_q_data  in  ACC_WIDTH  signed Q accumulator for the current lane
s_valid  in  1  lane pair valid
s_last  in  1  final lane of frame
s_ready  out  1  lane pair accepted when s_valid && s_ready
m_axis_tdata  out  AXI_DATA_WIDTH  sign-extended I/Q, or zero-extended Mag
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last lane of the current channel block
m_axis_tid  out  2  0 = I, 1 = Q, 2 = Mag
m_axis_tuser  out  LANE_W  lane index
o_peak_lane  out  LANE_W  lane index of the frame peak
o_peak_mag  out  MAG_W  peak magnitude
o_peak_valid  out  1  one-cycle pulse when the peak outputs update
o_det_count  out  LANE_W+1  lanes in the frame with mag >= threshold
o_frame_count  out  32  good frames completed
o_frame_err  out  1  sticky framing error
o_busy  out  1  state != IDLE

Function
REQ-007 FSM states: IDLE, CAPTURE, DRAIN, EMIT, DONE.
REQ-008 IDLE -> CAPTURE when i_enable=1; mode, mask and threshold are latched on that transition.
REQ-009 s_ready SHALL be 1 only in CAPTURE. Lane index starts at 0 and increments on each accepted pair; pairs are written to I, Q and Mag buffers of depth NUM_LANES.
REQ-010 Magnitude pipeline has 2 stages: stage 1 = abs; stage 2 = mag mode. All arithmetic is in MAG_W bits. abs(most-negative) SHALL be 2^(ACC_WIDTH-1) with no wrap. min/2 truncates.
REQ-011 Peak rule: a strict > comparison, so on equal magnitudes the lowest lane wins. An all-zero frame gives peak lane 0, peak mag 0.
REQ-012 Detection count: a lane counts if mag >= threshold.
REQ-013 Accepted pair with s_last=1 at lane NUM_LANES-1 -> DRAIN.
- DRAIN lasts 2 cycles.
- At DRAIN exit: update o_peak_lane, o_peak_mag and o_det_count; pulse o_peak_valid; increment o_frame_count (wraps at 2^32).
- Then go to EMIT, or to DONE if the mask is 0.
REQ-014 Framing error: s_last at a lane != NUM_LANES-1, or lane NUM_LANES-1 accepted without s_last.
- Set o_frame_err (sticky until rst).
- Discard the frame: no status update, no emit.
- Go to IDLE on the next cycle.
REQ-015 EMIT order is I, then Q, then Mag, skipping channels that are masked off. Each block is lanes 0..NUM_LANES-1 with tlast on lane NUM_LANES-1.
REQ-016 AXI rule: once tvalid=1, tdata, tid, tuser and tlast SHALL hold until tready=1. With tready held at 1, throughput SHALL be 1 beat per cycle (prefetch for the 1-cycle buffer read latency).
REQ-017 EMIT -> DONE after the final beat handshakes. DONE -> IDLE in 1 cycle.
REQ-018 Changes to the i_* configuration inputs outside IDLE have no effect on the frame in flight. Deasserting i_enable mid-frame does not abort the frame.

Reset
REQ-019 With rst=1 at a clock edge:
- state = IDLE; all outputs = 0; s_ready = 0.
- Lane and emit counters cleared; o_frame_err cleared.
- Buffer contents need not be cleared.
REQ-020 Reset mid-CAPTURE or mid-EMIT SHALL abort immediately. m_axis_tvalid drops on the cycle after the reset edge. There is no partial status update.

Structure
REQ-021 Package qedmma_corr_pkg holds:
- streamer state enum;
- tid constants TID_I=0, TID_Q=1, TID_MAG=2;
- mag mode constants.
REQ-022 Sub-module qedmma_iq_mag_unit holds the 2-stage abs/magnitude pipeline. Both modes are selected by an input.

Verification (NUM_LANES=8, ACC_WIDTH=16)
REQ-023 Mode 0, mask 7. Lane 5 = (I=-300, Q=400), others (1,1).
-> peak lane 5, mag 700, o_peak_valid pulse; 24 beats with tid 0/1/2 and tlast at beats 8/16/24.
REQ-024 Mode 1. Lane 2 = (I=-32768, Q=100), threshold 1000.
-> lane 2 mag 32818, det_count 1, no sign wrap.
REQ-025 Lanes 3 and 6 both (500,0), mask 4.
-> peak lane 3; only the 8 Mag beats are emitted.
REQ-026 s_last at lane 4.
-> o_frame_err=1, frame_count unchanged, no output beats; the next good frame is processed normally.
REQ-027 Random tready with 30% stall, mask 3.
-> 16 beats in lane order; data stable while stalled; no loss or duplication.
REQ-028 rst asserted at EMIT beat 10.
-> tvalid=0 on the next cycle; status = 0; a clean frame afterwards completes with frame_count=1.
